// File: rtl/sequential_divider.sv
// sequential_divider: 16-bit by 8-bit unsigned restoring divider.
// One shift-subtract step per clock, MSB first, over 16 RUN cycles.
// A zero divisor bypasses RUN and reports div_by_zero with the result.
// Optional build macro: DIV_EARLY_EXIT_EN. When defined, dividend < divisor
// finishes straight from IDLE. When undefined, every nonzero divisor takes
// the full 16 RUN cycles. Results are the same in both builds.
module sequential_divider (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [7:0]  divisor,
   output logic [15:0] quotient,
   output logic [7:0]  remainder,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e      state_q;
   logic [15:0] dvd_q;      // dividend shifts out the top; quotient bits shift in below
   logic [7:0]  dvs_q;
   logic [7:0]  rem_q;
   logic [3:0]  cnt_q;

   logic [8:0]  rem_shift;
   logic [8:0]  diff;
   logic        q_bit;
   logic [7:0]  rem_next;
   logic        early_exit;

   // One restoring step: shift in the next dividend bit and trial-subtract
   always_comb begin
      rem_shift = {rem_q, dvd_q[15]};
      diff      = rem_shift - {1'b0, dvs_q};
      // rem_shift < 2*divisor, so bit 8 of the difference is the borrow
      q_bit     = ~diff[8];
      rem_next  = q_bit ? diff[7:0] : rem_shift[7:0];
   end

   // Decide whether an accepted start can finish without running
   always_comb begin
`ifdef DIV_EARLY_EXIT_EN
      early_exit = (divisor != 8'd0) && (dividend < {8'd0, divisor});
`else
      early_exit = 1'b0;
`endif
   end

   // Control FSM with registered outputs and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         dvd_q       <= 16'd0;
         dvs_q       <= 8'd0;
         rem_q       <= 8'd0;
         cnt_q       <= 4'd0;
         quotient    <= 16'd0;
         remainder   <= 8'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               done <= 1'b0;
               if (start) begin
                  dvd_q       <= dividend;
                  dvs_q       <= divisor;
                  rem_q       <= 8'd0;
                  cnt_q       <= 4'd0;
                  div_by_zero <= 1'b0;
                  if (divisor == 8'd0) begin
                     state_q     <= StDone;
                     done        <= 1'b1;
                     div_by_zero <= 1'b1;
                     quotient    <= 16'hFFFF;
                     remainder   <= dividend[7:0];
                  end else if (early_exit) begin
                     state_q   <= StDone;
                     done      <= 1'b1;
                     quotient  <= 16'd0;
                     remainder <= dividend[7:0];
                  end else begin
                     state_q <= StRun;
                     busy    <= 1'b1;
                  end
               end
            end
            StRun: begin
               dvd_q <= {dvd_q[14:0], q_bit};
               rem_q <= rem_next;
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_q   <= StDone;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  quotient  <= {dvd_q[14:0], q_bit};
                  remainder <= rem_next;
               end
            end
            StDone: begin
               done    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/sequential_divider.md
SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 The block SHALL have these ports: clk  input  1  rising-edge clock for all state.
REQ-002 The block SHALL have these ports: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 The block SHALL have these ports: start  input  1  request to begin a division; sampled only in IDLE.
REQ-004 The block SHALL have these ports: dividend  input  16  unsigned dividend; captured on the accepted-start edge.
REQ-005 The block SHALL have these ports: divisor  input  8  unsigned divisor; captured on the accepted-start edge.
REQ-006 The block SHALL have these ports: quotient  output  16  unsigned quotient; registered.
REQ-007 The block SHALL have these ports: remainder  output  8  unsigned remainder; registered.
REQ-008 The block SHALL have these ports: busy  output  1  high while a division is in progress (RUN state).
REQ-009 The block SHALL have these ports: done  output  1  one-cycle pulse; results valid.
REQ-010 The block SHALL have these ports: div_by_zero  output  1  set with done when the captured divisor was 0; held until next accepted start.

Function
REQ-011 The block SHALL implement states IDLE, RUN and DONE.
REQ-012 In IDLE with start=1 at edge N, the block SHALL capture the operands, clear div_by_zero and enter RUN (busy=1 from N+1).
REQ-013 In RUN, the block SHALL perform one restoring shift-subtract step per cycle, MSB first, using a 9-bit partial remainder, for exactly 16 cycles.
REQ-014 After the 16th RUN cycle, the block SHALL enter DONE: done=1 for exactly one cycle (edge N+17), busy=0, then return to IDLE.
REQ-015 quotient and remainder SHALL update only on entry to DONE and SHALL hold their values until the next DONE or reset.
REQ-016 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for all divisor != 0.
REQ-017 For divisor=0, the block SHALL skip RUN (IDLE->DONE, done at N+1) with quotient=16'hFFFF, remainder=dividend[7:0] and div_by_zero=1.
REQ-018 start asserted in RUN or DONE SHALL be ignored; the in-flight operand registers SHALL not change.
REQ-019 Operand inputs SHALL be don't-care after the accepted-start edge.
REQ-020 start held high continuously SHALL produce back-to-back divisions, one per 18 cycles (IDLE-RUN×16-DONE).

Reset
REQ-021 On a clk edge with reset=1, the block SHALL enter IDLE and set quotient=0, remainder=0, busy=0, done=0, div_by_zero=0.
REQ-022 reset SHALL take priority over start and over any in-progress RUN; an aborted division SHALL produce no done pulse.

Configuration
REQ-023 With macro DIV_EARLY_EXIT_EN defined, an accepted start with divisor != 0 and dividend < divisor SHALL go IDLE->DONE (done at N+1) with quotient=0 and remainder=dividend[7:0].
REQ-024 Without DIV_EARLY_EXIT_EN, all nonzero-divisor cases SHALL take the full 16 RUN cycles (done at N+17); results SHALL be identical in both builds.

Verification
REQ-025 The bench SHALL cover: dividend=1000, divisor=7, start pulse -> done at N+17, quotient=142, remainder=6, div_by_zero=0.
REQ-026 The bench SHALL cover: dividend=65535, divisor=255 -> quotient=257, remainder=0; dividend=65535, divisor=1 -> quotient=65535, remainder=0.
REQ-027 The bench SHALL cover: dividend=5, divisor=0 -> done at N+1, quotient=16'hFFFF, remainder=5, div_by_zero=1; next valid start clears div_by_zero.
REQ-028 The bench SHALL cover: dividend=3, divisor=10 -> quotient=0, remainder=3; done at N+1 with DIV_EARLY_EXIT_EN, at N+17 without.
REQ-029 The bench SHALL cover: start, then reset=1 at N+8 -> IDLE, all outputs 0, no done pulse; re-issuing 1000/7 gives the correct result.
REQ-030 The bench SHALL cover: start with 1000/7, a second start with 100/3 at N+5 -> second start ignored, result 142 r 6, busy stays 1 through RUN.
